// File: rtl/uart_sector_packer_pkg.sv
// Constants shared by the UART sector packer and the SD sector writer.
package uart_sector_packer_pkg;

    localparam logic [9:0]  SECTOR_BYTES         = 10'd512;
    localparam logic [9:0]  SECTOR_LAST          = 10'd511;
    localparam logic [31:0] DEFAULT_START_SECTOR = 32'd1000;

    typedef logic [1:0] drain_state_t;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_REQ       = 2'd1;
    localparam logic [1:0] ST_DRAIN     = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE = 2'd3;

endpackage

// File: rtl/sector_bank_ram.sv
// Two 512-byte sector banks in one 1024x8 simple dual-port RAM, address {bank, ptr}.
module sector_bank_ram (
    input  logic       clk,
    input  logic       we,
    input  logic [9:0] waddr,
    input  logic [7:0] wdata,
    input  logic       re,
    input  logic [9:0] raddr,
    output logic [7:0] rdata
);

    logic [7:0] mem [0:1023];
    logic [7:0] rdata_q;

    // Registered read; contents are never reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/uart_sector_packer.sv
// Packs a UART byte stream into 512-byte SD sectors using two ping-pong banks.
module uart_sector_packer
    import uart_sector_packer_pkg::*;
#(
    parameter logic [31:0] START_SECTOR = DEFAULT_START_SECTOR,
    parameter logic [23:0] IDLE_TIMEOUT = 24'd5_000_000,
    parameter logic [7:0]  PAD_BYTE     = 8'h00
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        wr_req,
    output logic [31:0] wr_sector,
    input  logic        wr_data_req,
    output logic [7:0]  wr_data,
    input  logic        wr_done,
    output logic        overflow,
    output logic [15:0] sector_count
);

    logic             fill_bank_q, fill_bank_d;
    logic [8:0]       fill_ptr_q, fill_ptr_d;
    logic [1:0]       bank_full_q, bank_full_d;
    logic [1:0][9:0]  bank_len_q, bank_len_d;
    logic [23:0]      idle_cnt_q, idle_cnt_d;
    logic             overflow_q, overflow_d;

    drain_state_t     state_q, state_d;
    logic             drain_bank_q, drain_bank_d;
    logic [9:0]       drain_ptr_q, drain_ptr_d;
    logic             wr_req_q, wr_req_d;
    logic [31:0]      wr_sector_q, wr_sector_d;
    logic [15:0]      sector_count_q, sector_count_d;
    logic             rd_seen_q, rd_seen_d;
    logic             pad_q, pad_d;

    logic [1:0]       free_mask;
    logic [1:0]       bank_avail;
    logic             ram_we;
    logic             ram_re;
    logic [7:0]       ram_rdata;

    always_comb begin
        state_d        = state_q;
        drain_bank_d   = drain_bank_q;
        drain_ptr_d    = drain_ptr_q;
        wr_req_d       = 1'b0;
        wr_sector_d    = wr_sector_q;
        sector_count_d = sector_count_q;
        rd_seen_d      = rd_seen_q;
        pad_d          = pad_q;
        free_mask      = 2'b00;
        ram_re         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                drain_ptr_d = '0;
                if (bank_full_q[drain_bank_q]) begin
                    state_d  = ST_REQ;
                    wr_req_d = 1'b1;
                end
            end
            ST_REQ: begin
                state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (wr_data_req) begin
                    ram_re      = 1'b1;
                    rd_seen_d   = 1'b1;
                    // Bytes past the committed length are padded, always yielding 512.
                    pad_d       = (drain_ptr_q >= bank_len_q[drain_bank_q]);
                    drain_ptr_d = drain_ptr_q + 10'd1;
                    if (drain_ptr_q == SECTOR_LAST) begin
                        state_d = ST_WAIT_DONE;
                    end
                end
            end
            ST_WAIT_DONE: begin
                if (wr_done) begin
                    free_mask[drain_bank_q] = 1'b1;
                    drain_bank_d   = ~drain_bank_q;
                    wr_sector_d    = wr_sector_q + 32'd1;
                    sector_count_d = sector_count_q + 16'd1;
                    state_d        = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A bank released by wr_done this cycle is already writable by the fill side.
    assign bank_avail = bank_full_q & ~free_mask;

    always_comb begin
        fill_bank_d = fill_bank_q;
        fill_ptr_d  = fill_ptr_q;
        bank_full_d = bank_avail;
        bank_len_d  = bank_len_q;
        idle_cnt_d  = idle_cnt_q;
        overflow_d  = overflow_q;
        ram_we      = 1'b0;
        if (rx_valid) begin
            idle_cnt_d = '0;
            if (bank_avail[fill_bank_q]) begin
                overflow_d = 1'b1;
            end else begin
                ram_we = 1'b1;
                if (fill_ptr_q == SECTOR_LAST[8:0]) begin
                    bank_full_d[fill_bank_q] = 1'b1;
                    bank_len_d[fill_bank_q]  = SECTOR_BYTES;
                    fill_ptr_d               = '0;
                    fill_bank_d              = ~fill_bank_q;
                end else begin
                    fill_ptr_d = fill_ptr_q + 9'd1;
                end
            end
        end else if (fill_ptr_q != 9'd0) begin
            idle_cnt_d = idle_cnt_q + 24'd1;
            if (idle_cnt_d == IDLE_TIMEOUT) begin
                bank_full_d[fill_bank_q] = 1'b1;
                bank_len_d[fill_bank_q]  = {1'b0, fill_ptr_q};
                fill_ptr_d               = '0;
                fill_bank_d              = ~fill_bank_q;
                idle_cnt_d               = '0;
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            fill_bank_q    <= 1'b0;
            fill_ptr_q     <= '0;
            bank_full_q    <= '0;
            bank_len_q     <= '0;
            idle_cnt_q     <= '0;
            overflow_q     <= 1'b0;
            state_q        <= ST_IDLE;
            drain_bank_q   <= 1'b0;
            drain_ptr_q    <= '0;
            wr_req_q       <= 1'b0;
            wr_sector_q    <= START_SECTOR;
            sector_count_q <= '0;
            rd_seen_q      <= 1'b0;
            pad_q          <= 1'b0;
        end else begin
            fill_bank_q    <= fill_bank_d;
            fill_ptr_q     <= fill_ptr_d;
            bank_full_q    <= bank_full_d;
            bank_len_q     <= bank_len_d;
            idle_cnt_q     <= idle_cnt_d;
            overflow_q     <= overflow_d;
            state_q        <= state_d;
            drain_bank_q   <= drain_bank_d;
            drain_ptr_q    <= drain_ptr_d;
            wr_req_q       <= wr_req_d;
            wr_sector_q    <= wr_sector_d;
            sector_count_q <= sector_count_d;
            rd_seen_q      <= rd_seen_d;
            pad_q          <= pad_d;
        end
    end

    sector_bank_ram u_ram (
        .clk   (sys_clk),
        .we    (ram_we),
        .waddr ({fill_bank_q, fill_ptr_q}),
        .wdata (rx_data),
        .re    (ram_re),
        .raddr ({drain_bank_q, drain_ptr_q[8:0]}),
        .rdata (ram_rdata)
    );

    assign wr_req       = wr_req_q;
    assign wr_sector    = wr_sector_q;
    assign wr_data      = rd_seen_q ? (pad_q ? PAD_BYTE : ram_rdata) : 8'h00;
    assign overflow     = overflow_q;
    assign sector_count = sector_count_q;

endmodule

// File: tb/tb_uart_sector_packer.sv
// Randomized bench for uart_sector_packer against a byte-queue sector model.
module tb_uart_sector_packer;

    localparam logic [31:0] START = 32'd1000;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        wr_req;
    logic [31:0] wr_sector;
    logic        wr_data_req;
    logic [7:0]  wr_data;
    logic        wr_done;
    logic        overflow;
    logic [15:0] sector_count;

    int tests = 0;
    int fails = 0;

    always #5 sys_clk = ~sys_clk;

    uart_sector_packer #(
        .START_SECTOR (START),
        .IDLE_TIMEOUT (24'd1000),
        .PAD_BYTE     (8'h00)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .wr_req       (wr_req),
        .wr_sector    (wr_sector),
        .wr_data_req  (wr_data_req),
        .wr_data      (wr_data),
        .wr_done      (wr_done),
        .overflow     (overflow),
        .sector_count (sector_count)
    );

    // Reference model: bytes of the open sector, committed sector payloads, sectors awaiting wr_done.
    logic [7:0]  cur_q[$];
    logic [7:0]  exp_bytes[$];
    int          pending;
    bit          exp_ovf;
    logic [31:0] exp_sector;
    logic [15:0] exp_count;
    logic [31:0] req_q[$];

    always @(negedge sys_clk) begin
        if (wr_req === 1'b1) req_q.push_back(wr_sector);
    end

    function automatic void model_commit();
        for (int i = 0; i < 512; i++) begin
            if (i < cur_q.size()) exp_bytes.push_back(cur_q[i]);
            else exp_bytes.push_back(8'h00);
        end
        cur_q.delete();
        pending++;
    endfunction

    function automatic void model_rx(input logic [7:0] b);
        if (pending == 2) begin
            exp_ovf = 1'b1;
        end else begin
            cur_q.push_back(b);
            if (cur_q.size() == 512) model_commit();
        end
    endfunction

    function automatic void model_timeout();
        if (exp_bytes.size() == 0 && cur_q.size() > 0) model_commit();
    endfunction

    function automatic void model_done();
        pending--;
        exp_sector = exp_sector + 32'd1;
        exp_count  = exp_count + 16'd1;
    endfunction

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst = 1'b1; rx_valid = 1'b0; wr_data_req = 1'b0; wr_done = 1'b0;
        @(negedge sys_clk);
        @(negedge sys_clk);
        cur_q.delete(); exp_bytes.delete(); req_q.delete();
        pending = 0; exp_ovf = 1'b0; exp_sector = START; exp_count = 16'd0;
        sys_rst = 1'b0;
    endtask

    // mode 0: random bytes, 1: counting 0x00..0xFF, 2: constant 0xA5
    task automatic send_burst(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            logic [7:0] b;
            if (mode == 1) b = 8'(i);
            else if (mode == 2) b = 8'hA5;
            else b = 8'($urandom);
            @(negedge sys_clk);
            rx_valid = 1'b1; rx_data = b;
            model_rx(b);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge sys_clk);
                rx_valid = 1'b0;
            end
        end
        @(negedge sys_clk);
        rx_valid = 1'b0;
    endtask

    task automatic drain_data(input int n_req, input string name);
        int waited = 0;
        int issued = 0;
        int checked = 0;
        int bad = 0;
        int first_bad = 0;
        logic [7:0] got_b = 8'h00;
        logic [7:0] exp_b = 8'h00;
        logic [31:0] sec;
        while (req_q.size() == 0 && waited < 3000) begin
            @(negedge sys_clk);
            waited++;
        end
        tests++;
        if (req_q.size() == 0) begin
            fails++;
            $display("FAIL %s_wr_req: no wr_req after %0d cycles, required one", name, waited);
            return;
        end
        sec = req_q.pop_front();
        tests++;
        if (sec !== exp_sector) begin
            fails++;
            $display("FAIL %s_wr_sector: got %0d, required %0d", name, sec, exp_sector);
        end
        model_timeout();
        while (checked < n_req) begin
            @(negedge sys_clk);
            if (wr_data_req) begin
                if (wr_data !== exp_bytes[checked]) begin
                    if (bad == 0) begin
                        first_bad = checked; got_b = wr_data; exp_b = exp_bytes[checked];
                    end
                    bad++;
                end
                checked++;
            end
            wr_data_req = (issued < n_req) && ($urandom_range(0, 7) != 0);
            if (wr_data_req) issued++;
        end
        wr_data_req = 1'b0;
        if (n_req == 512) repeat (512) void'(exp_bytes.pop_front());
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL %s_wr_data: %0d bad bytes, byte %0d got %02h, required %02h",
                     name, bad, first_bad, got_b, exp_b);
        end
        $display("[TB] %s: sector %0d, %0d bytes read", name, sec, checked);
    endtask

    task automatic done_pulse(input string name);
        @(negedge sys_clk);
        wr_done = 1'b1;
        model_done();
        @(negedge sys_clk);
        wr_done = 1'b0;
        tests++;
        if (sector_count !== exp_count) begin
            fails++;
            $display("FAIL %s_sector_count: got %0d, required %0d", name, sector_count, exp_count);
        end
        tests++;
        if (wr_sector !== exp_sector) begin
            fails++;
            $display("FAIL %s_next_sector: got %0d, required %0d", name, wr_sector, exp_sector);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        tests++;
        if (wr_req !== 1'b0 || wr_data !== 8'h00 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL %s_flags: got wr_req=%b wr_data=%02h overflow=%b, required 0/00/0",
                     name, wr_req, wr_data, overflow);
        end
        tests++;
        if (sector_count !== 16'd0 || wr_sector !== START) begin
            fails++;
            $display("FAIL %s_counters: got count=%0d sector=%0d, required 0/%0d",
                     name, sector_count, wr_sector, START);
        end
    endtask

    task automatic test_reset();
        sys_rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; wr_data_req = 1'b0; wr_done = 1'b0;
        @(negedge sys_clk);
        @(negedge sys_clk);
        check_reset_outputs("reset");
        do_reset();
        $display("[TB] reset: outputs checked");
    endtask

    task automatic test_full_sector();
        do_reset();
        send_burst(512, 1);
        drain_data(512, "full");
        done_pulse("full");
    endtask

    task automatic test_timeout();
        int waited = 0;
        do_reset();
        send_burst(10, 2);
        while (wr_req !== 1'b1 && waited < 2000) begin
            @(negedge sys_clk);
            waited++;
        end
        tests++;
        if (waited < 998 || waited > 1003) begin
            fails++;
            $display("FAIL timeout_latency: got %0d idle cycles, required 998..1003", waited);
        end
        drain_data(512, "timeout");
        done_pulse("timeout");
    endtask

    task automatic test_ignored();
        do_reset();
        repeat (4) begin
            @(negedge sys_clk); wr_data_req = 1'b1; wr_done = 1'b1;
        end
        @(negedge sys_clk); wr_data_req = 1'b0; wr_done = 1'b0;
        repeat (3) @(negedge sys_clk);
        tests++;
        if (sector_count !== 16'd0 || req_q.size() != 0) begin
            fails++;
            $display("FAIL idle_ignore: got count=%0d reqs=%0d, required 0/0", sector_count, req_q.size());
        end
        send_burst(512, 0);
        repeat (5) @(negedge sys_clk);
        wr_done = 1'b1;
        @(negedge sys_clk); wr_done = 1'b0;
        @(negedge sys_clk);
        tests++;
        if (sector_count !== exp_count) begin
            fails++;
            $display("FAIL drain_ignore_done: got count=%0d, required %0d", sector_count, exp_count);
        end
        drain_data(512, "ignored");
        done_pulse("ignored");
    endtask

    task automatic test_overflow();
        do_reset();
        send_burst(1536, 0);
        tests++;
        if (overflow !== exp_ovf || exp_ovf !== 1'b1) begin
            fails++;
            $display("FAIL overflow_set: got %b, required %b", overflow, exp_ovf);
        end
        drain_data(512, "ovf_a");
        done_pulse("ovf_a");
        drain_data(512, "ovf_b");
        done_pulse("ovf_b");
        repeat (1200) @(negedge sys_clk);
        tests++;
        if (overflow !== 1'b1 || req_q.size() != 0) begin
            fails++;
            $display("FAIL overflow_sticky: got overflow=%b reqs=%0d, required 1/0", overflow, req_q.size());
        end
    endtask

    task automatic test_same_cycle_free();
        logic [7:0] b;
        do_reset();
        send_burst(512, 0);
        drain_data(512, "same_a");
        send_burst(511, 0);
        b = 8'($urandom);
        @(negedge sys_clk);
        rx_valid = 1'b1; rx_data = b; wr_done = 1'b1;
        model_rx(b);
        model_done();
        @(negedge sys_clk);
        rx_valid = 1'b0; wr_done = 1'b0;
        send_burst(100, 0);
        tests++;
        if (overflow !== 1'b0) begin
            fails++;
            $display("FAIL same_cycle_overflow: got %b, required 0", overflow);
        end
        drain_data(512, "same_b");
        done_pulse("same_b");
        drain_data(512, "same_a2");
        done_pulse("same_a2");
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        send_burst(512, 0);
        drain_data(512, "pre_rst");
        done_pulse("pre_rst");
        send_burst(512, 0);
        drain_data(200, "mid_rst");
        @(negedge sys_clk);
        sys_rst = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        do_reset();
        repeat (1500) @(negedge sys_clk);
        tests++;
        if (req_q.size() != 0) begin
            fails++;
            $display("FAIL mid_rst_no_req: got %0d wr_req, required 0", req_q.size());
        end
        send_burst(512, 1);
        drain_data(512, "post_rst");
        done_pulse("post_rst");
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int k = 0; k < 2; k++) begin
            send_burst(1024, 0);
            drain_data(512, "b2b");
            done_pulse("b2b");
            drain_data(512, "b2b");
            done_pulse("b2b");
        end
        tests++;
        if (sector_count !== 16'd4 || wr_sector !== START + 32'd4) begin
            fails++;
            $display("FAIL b2b_final: got count=%0d sector=%0d, required 4/%0d",
                     sector_count, wr_sector, START + 32'd4);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 3; k++) begin
            int n;
            n = $urandom_range(1, 1023);
            send_burst(n, 0);
            while (exp_bytes.size() > 0 || cur_q.size() > 0) begin
                drain_data(512, "rand");
                done_pulse("rand");
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_sector();
        test_timeout();
        test_ignored();
        test_overflow();
        test_same_cycle_free();
        test_reset_mid_drain();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
